// File: rtl/echo_pkg.sv
// Shared widths, FSM state encoding and output saturation for the echo engine.
package echo_pkg;

   localparam int unsigned SAMPLE_W  = 16;
   localparam int unsigned SUM_W     = SAMPLE_W + 2;
   localparam int unsigned PROD_W    = 24;
   localparam int unsigned VOL_W     = 8;
   localparam int unsigned VOL_SHIFT = 7;
   localparam int unsigned VOL_MAX   = 128;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RD   = 2'd1,
      CALC = 2'd2,
      WR   = 2'd3
   } echo_state_t;

   // Clip a widened sum back into the signed 16-bit sample range.
   function automatic logic signed [SAMPLE_W-1:0] sat16(input logic signed [SUM_W-1:0] s);
      localparam logic signed [SUM_W-1:0] SAT_MAX = SUM_W'(32767);
      localparam logic signed [SUM_W-1:0] SAT_MIN = -SUM_W'(32768);
      if (s > SAT_MAX)      return 16'sh7fff;
      else if (s < SAT_MIN) return 16'sh8000;
      else                  return SAMPLE_W'(s);
   endfunction

endpackage

// File: rtl/echo_engine_if.sv
// Sample stream and echo-parameter bundle between the codec path/controller and the engine.
//   sample_in/_valid      : input sample and one-cycle strobe
//   delay_time/volume     : echo delay D (samples) and gain V (0..128)
//   disabled              : bypass the echo
//   sample_out/_valid     : output sample and one-cycle strobe
//   overrun               : sticky flag, a strobe was dropped while busy
interface echo_engine_if;

   logic signed [echo_pkg::SAMPLE_W-1:0] sample_in;
   logic                                 sample_in_valid;
   logic [31:0]                          delay_time;
   logic [31:0]                          delay_volume;
   logic                                 disabled;
   logic signed [echo_pkg::SAMPLE_W-1:0] sample_out;
   logic                                 sample_out_valid;
   logic                                 overrun;

   modport master (
      output sample_in, sample_in_valid, delay_time, delay_volume, disabled,
      input  sample_out, sample_out_valid, overrun
   );

   modport slave (
      input  sample_in, sample_in_valid, delay_time, delay_volume, disabled,
      output sample_out, sample_out_valid, overrun
   );

endinterface

// File: rtl/echo_delay_ram.sv
// Single-port synchronous delay line storage, read-first, one-cycle read latency.
//   i_clk   : clock
//   i_we    : write enable
//   i_addr  : read/write address
//   i_wdata : write data
//   o_rdata : data at the address presented on the previous clock
module echo_delay_ram #(
   parameter int unsigned ADDR_W = 16,
   parameter int unsigned DATA_W = 16
) (
   input  logic              i_clk,
   input  logic              i_we,
   input  logic [ADDR_W-1:0] i_addr,
   input  logic [DATA_W-1:0] i_wdata,
   output logic [DATA_W-1:0] o_rdata
);

   localparam int unsigned DEPTH = 2 ** ADDR_W;

   logic [DATA_W-1:0] r_mem [DEPTH];
   logic [DATA_W-1:0] r_q;

   // No reset so the array maps onto block RAM.
   always_ff @(posedge i_clk) begin
      if (i_we) r_mem[i_addr] <= i_wdata;
      r_q <= r_mem[i_addr];
   end

   assign o_rdata = r_q;

endmodule

// File: rtl/echo_engine.sv
// Recursive echo: y[n] = sat16(x[n] + (y[n-D]*V) >>> 7) over a circular delay buffer.
//   CLK     : clock
//   reset_n : asynchronous active-low reset
//   bus     : echo_engine_if slave (sample stream, echo parameters, outputs)
module echo_engine
   import echo_pkg::*;
#(
   parameter int unsigned ADDR_W = 16
) (
   input  logic          CLK,
   input  logic          reset_n,
   echo_engine_if.slave  bus
);

   localparam int unsigned        DEPTH = 2 ** ADDR_W;
   localparam logic [ADDR_W-1:0]  D_MAX = ADDR_W'(DEPTH - 1);

   echo_state_t                 r_state, w_next;
   logic signed [SAMPLE_W-1:0]  r_x;
   logic [ADDR_W-1:0]           r_d;
   logic [VOL_W-1:0]            r_v;
   logic                        r_dis;
   logic [ADDR_W-1:0]           r_wr_ptr;
   logic [ADDR_W-1:0]           r_fill;
   logic signed [SAMPLE_W-1:0]  r_sample_out;
   logic                        r_valid;
   logic                        r_overrun;

   logic [ADDR_W-1:0]           w_d_clamp;
   logic [VOL_W-1:0]            w_v_clamp;
   logic                        w_ram_we;
   logic [ADDR_W-1:0]           w_ram_addr;
   logic [SAMPLE_W-1:0]         w_ram_q;
   logic signed [SAMPLE_W-1:0]  w_dly;
   logic signed [PROD_W-1:0]    w_prod;
   logic signed [SUM_W-1:0]     w_sum;
   logic signed [SAMPLE_W-1:0]  w_y;

   // Parameter clamps applied when a sample is accepted.
   always_comb begin
      w_d_clamp = ADDR_W'(bus.delay_time);
      if (bus.delay_time == 32'd0)
         w_d_clamp = ADDR_W'(1);
      else if (bus.delay_time > 32'(DEPTH - 1))
         w_d_clamp = D_MAX;

      w_v_clamp = VOL_W'(bus.delay_volume);
      if (bus.delay_volume > 32'(VOL_MAX))
         w_v_clamp = VOL_W'(VOL_MAX);
   end

   // Single port: write slot in WR, delayed read slot otherwise (mod DEPTH wrap is free).
   assign w_ram_we   = (r_state == WR);
   assign w_ram_addr = (r_state == WR) ? r_wr_ptr : (r_wr_ptr - r_d);

   echo_delay_ram #(
      .ADDR_W (ADDR_W),
      .DATA_W (SAMPLE_W)
   ) u_ram (
      .i_clk   (CLK),
      .i_we    (w_ram_we),
      .i_addr  (w_ram_addr),
      .i_wdata (r_sample_out),
      .o_rdata (w_ram_q)
   );

   // MAC datapath; locations not yet written since reset read as silence.
   assign w_dly  = (r_fill >= r_d) ? $signed(w_ram_q) : '0;
   assign w_prod = PROD_W'(w_dly) * PROD_W'($signed({1'b0, r_v}));
   assign w_sum  = SUM_W'(r_x) + SUM_W'(w_prod >>> VOL_SHIFT);
   assign w_y    = r_dis ? r_x : sat16(w_sum);

   // State register.
   always_ff @(posedge CLK or negedge reset_n) begin
      if (!reset_n) r_state <= IDLE;
      else          r_state <= w_next;
   end

   // Next-state logic: one sample per IDLE->RD->CALC->WR pass.
   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    if (bus.sample_in_valid) w_next = RD;
         RD:      w_next = CALC;
         CALC:    w_next = WR;
         WR:      w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   // Parameter latches, output register, pointer/fill bookkeeping and overrun flag.
   always_ff @(posedge CLK or negedge reset_n) begin
      if (!reset_n) begin
         r_x          <= '0;
         r_d          <= ADDR_W'(1);
         r_v          <= '0;
         r_dis        <= 1'b0;
         r_wr_ptr     <= '0;
         r_fill       <= '0;
         r_sample_out <= '0;
         r_valid      <= 1'b0;
         r_overrun    <= 1'b0;
      end else begin
         r_valid <= 1'b0;
         if (bus.sample_in_valid) begin
            if (r_state == IDLE) begin
               r_x   <= bus.sample_in;
               r_d   <= w_d_clamp;
               r_v   <= w_v_clamp;
               r_dis <= bus.disabled;
            end else begin
               r_overrun <= 1'b1;
            end
         end
         // Result is registered on entry to WR so the strobe lands 3 cycles after input.
         if (r_state == CALC) begin
            r_sample_out <= w_y;
            r_valid      <= 1'b1;
         end
         if (r_state == WR) begin
            r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
            if (r_fill != D_MAX) r_fill <= r_fill + ADDR_W'(1);
         end
      end
   end

   assign bus.sample_out       = r_sample_out;
   assign bus.sample_out_valid = r_valid;
   assign bus.overrun          = r_overrun;

endmodule

// File: tb/tb_echo_engine.sv
// Directed bench for echo_engine: a full-size instance and a 16-deep instance for wrap/limit cases.
module tb_echo_engine;

   logic clk = 1'b0;
   logic rst_m;
   logic rst_s;
   int   vectors = 0;
   int   errors  = 0;

   always #5 clk = ~clk;

   echo_engine_if bm ();
   echo_engine_if bs ();

   echo_engine u_main (
      .CLK     (clk),
      .reset_n (rst_m),
      .bus     (bm)
   );

   echo_engine #(.ADDR_W(4)) u_small (
      .CLK     (clk),
      .reset_n (rst_s),
      .bus     (bs)
   );

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Pulse reset on one instance.
   task automatic apply_reset(input bit sm);
      @(negedge clk);
      if (sm) rst_s = 1'b0; else rst_m = 1'b0;
      repeat (2) @(negedge clk);
      if (sm) rst_s = 1'b1; else rst_m = 1'b1;
   endtask

   // Send one sample and wait (bounded) for the result; lat = -1 when no strobe arrives.
   task automatic send(input bit sm, input logic signed [15:0] x,
                       output logic signed [15:0] y, output int lat);
      logic v;
      @(negedge clk);
      if (sm) begin bs.sample_in = x; bs.sample_in_valid = 1'b1; end
      else    begin bm.sample_in = x; bm.sample_in_valid = 1'b1; end
      @(negedge clk);
      if (sm) bs.sample_in_valid = 1'b0; else bm.sample_in_valid = 1'b0;
      lat = 1;
      v = sm ? bs.sample_out_valid : bm.sample_out_valid;
      while (!v && lat < 10) begin
         @(negedge clk);
         lat++;
         v = sm ? bs.sample_out_valid : bm.sample_out_valid;
      end
      y = sm ? bs.sample_out : bm.sample_out;
      if (!v) lat = -1;
   endtask

   task automatic test_reset();
      int spurious;
      rst_m = 1'b0;
      rst_s = 1'b0;
      repeat (3) @(negedge clk);
      vectors++;
      if (bm.sample_out !== 16'sd0) begin
         $display("FAIL reset_sample_out: got %0d expected 0", bm.sample_out); errors++;
      end
      vectors++;
      if (bm.sample_out_valid !== 1'b0) begin
         $display("FAIL reset_valid: got %b expected 0", bm.sample_out_valid); errors++;
      end
      vectors++;
      if (bm.overrun !== 1'b0 || bs.overrun !== 1'b0) begin
         $display("FAIL reset_overrun: got %b/%b expected 0/0", bm.overrun, bs.overrun); errors++;
      end
      rst_m = 1'b1;
      rst_s = 1'b1;
      spurious = 0;
      repeat (6) begin
         @(negedge clk);
         if (bm.sample_out_valid === 1'b1 || bs.sample_out_valid === 1'b1) spurious++;
      end
      vectors++;
      if (spurious != 0) begin
         $display("FAIL reset_release: got %0d valid strobes expected 0", spurious); errors++;
      end
   endtask

   task automatic test_impulse();
      int exp_y [12] = '{32767, 0, 0, 0, 16383, 0, 0, 0, 8191, 0, 0, 0};
      logic signed [15:0] y;
      int lat;
      apply_reset(1'b0);
      bm.disabled = 1'b0; bm.delay_time = 32'd4; bm.delay_volume = 32'd64;
      for (int n = 0; n < 12; n++) begin
         send(1'b0, (n == 0) ? 16'sd32767 : 16'sd0, y, lat);
         vectors++;
         if (y !== 16'(exp_y[n]) || lat !== 3) begin
            $display("FAIL impulse[%0d]: got y=%0d lat=%0d expected y=%0d lat=3", n, y, lat, exp_y[n]);
            errors++;
         end
         repeat (4) @(negedge clk);
      end
   endtask

   task automatic test_saturation();
      int exp_p [4] = '{20000, 32767, 32767, 32767};
      int exp_n [4] = '{-20000, -32768, -32768, -32768};
      logic signed [15:0] y;
      int lat;
      bm.disabled = 1'b0; bm.delay_time = 32'd1; bm.delay_volume = 32'd128;
      apply_reset(1'b0);
      for (int n = 0; n < 4; n++) begin
         send(1'b0, 16'sd20000, y, lat);
         vectors++;
         if (y !== 16'(exp_p[n])) begin
            $display("FAIL sat_pos[%0d]: got %0d expected %0d", n, y, exp_p[n]); errors++;
         end
      end
      apply_reset(1'b0);
      for (int n = 0; n < 4; n++) begin
         send(1'b0, -16'sd20000, y, lat);
         vectors++;
         if (y !== 16'(exp_n[n])) begin
            $display("FAIL sat_neg[%0d]: got %0d expected %0d", n, y, exp_n[n]); errors++;
         end
      end
   endtask

   task automatic test_bypass();
      logic signed [15:0] x, y;
      int lat;
      apply_reset(1'b0);
      bm.disabled = 1'b1; bm.delay_time = 32'd1; bm.delay_volume = 32'd128;
      for (int n = 0; n < 8; n++) begin
         x = (n == 7) ? 16'sd30000 : 16'($urandom);
         send(1'b0, x, y, lat);
         vectors++;
         if (y !== x || lat !== 3) begin
            $display("FAIL bypass[%0d]: got y=%0d lat=%0d expected y=%0d lat=3", n, y, lat, x);
            errors++;
         end
      end
      @(negedge clk);
      vectors++;
      if (bm.sample_out_valid !== 1'b0 || bm.sample_out !== 16'sd30000) begin
         $display("FAIL bypass_hold: got valid=%b y=%0d expected valid=0 y=30000",
                  bm.sample_out_valid, bm.sample_out);
         errors++;
      end
      // Bypassed x was stored, so the first echoed sample sees 30000 + 3000 and clips.
      bm.disabled = 1'b0;
      send(1'b0, 16'sd3000, y, lat);
      vectors++;
      if (y !== 16'sd32767) begin
         $display("FAIL bypass_reenable: got %0d expected 32767", y); errors++;
      end
   endtask

   task automatic test_param_latch();
      logic signed [15:0] y;
      int lat;
      apply_reset(1'b0);
      bm.disabled = 1'b0; bm.delay_time = 32'd1; bm.delay_volume = 32'd128;
      send(1'b0, 16'sd1000, y, lat);
      @(negedge clk);
      bm.sample_in = 16'sd1000; bm.sample_in_valid = 1'b1;
      @(negedge clk);
      bm.sample_in_valid = 1'b0;
      bm.delay_volume = 32'd0;
      bm.disabled = 1'b1;
      repeat (2) @(negedge clk);
      vectors++;
      if (bm.sample_out_valid !== 1'b1 || bm.sample_out !== 16'sd2000) begin
         $display("FAIL param_latch: got valid=%b y=%0d expected valid=1 y=2000",
                  bm.sample_out_valid, bm.sample_out);
         errors++;
      end
   endtask

   task automatic test_overrun();
      logic signed [15:0] y, got;
      int lat, cnt;
      apply_reset(1'b0);
      bm.disabled = 1'b1; bm.delay_time = 32'd1; bm.delay_volume = 32'd0;
      @(negedge clk);
      bm.sample_in = 16'sd111; bm.sample_in_valid = 1'b1;
      @(negedge clk);
      bm.sample_in = 16'sd222;
      @(negedge clk);
      bm.sample_in_valid = 1'b0;
      cnt = 0;
      got = '0;
      repeat (10) begin
         if (bm.sample_out_valid === 1'b1) begin cnt++; got = bm.sample_out; end
         @(negedge clk);
      end
      vectors++;
      if (cnt !== 1 || got !== 16'sd111) begin
         $display("FAIL overrun_drop: got %0d outputs last=%0d expected 1 output of 111", cnt, got);
         errors++;
      end
      vectors++;
      if (bm.overrun !== 1'b1) begin
         $display("FAIL overrun_set: got %b expected 1", bm.overrun); errors++;
      end
      send(1'b0, 16'sd5, y, lat);
      vectors++;
      if (bm.overrun !== 1'b1 || y !== 16'sd5) begin
         $display("FAIL overrun_sticky: got overrun=%b y=%0d expected 1/5", bm.overrun, y); errors++;
      end
      apply_reset(1'b0);
      vectors++;
      if (bm.overrun !== 1'b0) begin
         $display("FAIL overrun_clear: got %b expected 0", bm.overrun); errors++;
      end
   endtask

   // Small instance: 70000 clamps to DEPTH-1 = 15; 34 samples cross the pointer wrap twice.
   task automatic test_delay_clamp_wrap();
      logic signed [15:0] y, e;
      int lat;
      apply_reset(1'b1);
      bs.disabled = 1'b0; bs.delay_time = 32'd70000; bs.delay_volume = 32'd128;
      for (int n = 0; n < 34; n++) begin
         send(1'b1, (n == 0) ? 16'sd1000 : 16'sd0, y, lat);
         e = (n == 0 || n == 15 || n == 30) ? 16'sd1000 : 16'sd0;
         vectors++;
         if (y !== e || lat !== 3) begin
            $display("FAIL clamp_wrap[%0d]: got y=%0d lat=%0d expected y=%0d lat=3", n, y, lat, e);
            errors++;
         end
      end
   endtask

   // D=0 acts as 1 and V=300 acts as 128 (low 8 bits alone would give 44).
   task automatic test_zero_delay_vol_clamp();
      logic signed [15:0] y;
      int lat;
      apply_reset(1'b1);
      bs.disabled = 1'b0; bs.delay_time = 32'd0; bs.delay_volume = 32'd300;
      for (int n = 0; n < 4; n++) begin
         send(1'b1, (n == 0) ? 16'sd1000 : 16'sd0, y, lat);
         vectors++;
         if (y !== 16'sd1000) begin
            $display("FAIL d0_vclamp[%0d]: got %0d expected 1000", n, y); errors++;
         end
      end
   endtask

   task automatic test_reset_midstream();
      logic signed [15:0] y, e;
      int lat, cnt;
      apply_reset(1'b1);
      bs.disabled = 1'b0; bs.delay_time = 32'd15; bs.delay_volume = 32'd128;
      for (int n = 0; n < 20; n++) send(1'b1, 16'sd100, y, lat);
      @(negedge clk);
      bs.sample_in = 16'sd100; bs.sample_in_valid = 1'b1;
      @(negedge clk);
      bs.sample_in_valid = 1'b0;
      rst_s = 1'b0;
      repeat (2) @(negedge clk);
      rst_s = 1'b1;
      cnt = 0;
      repeat (6) begin
         @(negedge clk);
         if (bs.sample_out_valid === 1'b1) cnt++;
      end
      vectors++;
      if (cnt !== 0) begin
         $display("FAIL midreset_discard: got %0d strobes expected 0", cnt); errors++;
      end
      for (int n = 0; n < 17; n++) begin
         send(1'b1, 16'sd5, y, lat);
         e = (n < 15) ? 16'sd5 : 16'sd10;
         vectors++;
         if (y !== e) begin
            $display("FAIL midreset_stale[%0d]: got %0d expected %0d", n, y, e); errors++;
         end
      end
   endtask

   initial begin
      rst_m = 1'b1;
      rst_s = 1'b1;
      bm.sample_in = '0; bm.sample_in_valid = 1'b0; bm.delay_time = 32'd1;
      bm.delay_volume = 32'd0; bm.disabled = 1'b0;
      bs.sample_in = '0; bs.sample_in_valid = 1'b0; bs.delay_time = 32'd1;
      bs.delay_volume = 32'd0; bs.disabled = 1'b0;

      test_reset();
      test_impulse();
      test_saturation();
      test_bypass();
      test_param_latch();
      test_overrun();
      test_delay_clamp_wrap();
      test_zero_delay_vol_clamp();
      test_reset_midstream();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
